// File: rtl/bram_reader_pkg.sv
// Shared definitions for the BRAM burst reader: FSM encoding, legal RAM
// read latencies and the width of the credit/occupancy counters.
package bram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int LAT_LOW  = 1;
  localparam int LAT_HIGH = 2;

  // Counters must represent the full range 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_reader_fifo.sv
// Small show-ahead FIFO: the oldest entry is always presented on head_data,
// and head_data reads as zero while the FIFO is empty.
module bram_reader_fifo
  import bram_reader_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && (count != CW'(DEPTH));
  assign do_pop    = pop && (count != '0);
  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Fetches a burst of consecutive BRAM words and streams them out with
// valid/ready/last, hiding the RAM read latency behind a credit-checked FIFO.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 18,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic [ADDR_WIDTH:0]   cmd_len_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic                  ram_en_out,
  output logic                  ram_regce_out,
  input  logic [DATA_WIDTH-1:0] ram_dout_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  input  logic                  data_ready_in,
  output logic                  data_last_out,
  output logic                  busy_out
);

  localparam int CW   = credit_width(FIFO_DEPTH);
  localparam int TAIL = READ_LATENCY - LAT_LOW;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [ADDR_WIDTH:0]     remaining;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_last;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           fifo_count;
  logic [CW:0]             credit_used;
  logic                    credit_ok;
  logic                    issue;
  logic                    issue_last;
  logic                    pop;
  logic [DATA_WIDTH:0]     head;

  // A pop in the same cycle is deliberately ignored, keeping the check conservative.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok   = credit_used < (CW + 1)'(FIFO_DEPTH);
  assign issue       = (state == ISSUE) && credit_ok;
  assign issue_last  = remaining == (ADDR_WIDTH + 1)'(1);
  assign pop         = data_valid_out && data_ready_in;

  assign cmd_ready_out  = (state == IDLE);
  assign busy_out       = (state != IDLE);
  assign ram_en_out     = issue;
  assign ram_addr_out   = addr;
  assign ram_regce_out  = (READ_LATENCY == LAT_HIGH) ? pipe_valid[0] : 1'b0;
  assign data_valid_out = (fifo_count != '0);
  assign data_out       = head[DATA_WIDTH-1:0];
  assign data_last_out  = head[DATA_WIDTH];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_in && (cmd_len_in != '0)) begin
            addr      <= cmd_addr_in;
            remaining <= cmd_len_in;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            addr      <= addr + ADDR_WIDTH'(1);
            remaining <= remaining - (ADDR_WIDTH + 1)'(1);
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && data_last_out) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Latency pipe tracks each outstanding read so its data is captured on arrival.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      inflight   <= '0;
    end else begin
      pipe_valid[0] <= issue;
      pipe_last[0]  <= issue && issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
      end
      inflight <= inflight + CW'(issue) - CW'(pipe_valid[TAIL]);
    end
  end

  bram_reader_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .push      (pipe_valid[TAIL]),
    .push_data ({pipe_last[TAIL], ram_dout_in}),
    .pop       (pop),
    .head_data (head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against behavioural BRAM models with
// 2-cycle (regce-gated) and 1-cycle read latency, mem[i] = i + 0x100.
module tb_bram_stream_reader;

  localparam int DW = 18;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN;
  logic          cmdValid;
  logic [AW-1:0] cmdAddr;
  logic [AW:0]   cmdLen;
  logic          dataReady;
  logic          useLow;

  logic          cmdReady2, ramEn2, ramRegce2, dataValid2, dataLast2, busy2;
  logic [AW-1:0] ramAddr2;
  logic [DW-1:0] ramDout2, data2, stage2;
  logic          cmdReady1, ramEn1, ramRegce1, dataValid1, dataLast1, busy1;
  logic [AW-1:0] ramAddr1;
  logic [DW-1:0] ramDout1, data1;

  logic          cmdReady, ramEn, ramRegce, dataValid, dataLast, busy;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] dataOut;

  logic [DW-1:0] ramMem [1 << AW];

  int checks;
  int errors;

  logic [DW-1:0] gotWords[$];
  bit            gotLast[$];
  int            gotAddrs[$];
  int firstValid, lastHs, busyFall, creditViol, regceSeen, busyAt1, cmdReadyAtFall, timedOut;

  bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .FIFO_DEPTH(4)) dut2 (
    .clk_in(clk), .rst_n_in(rstN),
    .cmd_valid_in(cmdValid & ~useLow), .cmd_ready_out(cmdReady2),
    .cmd_addr_in(cmdAddr), .cmd_len_in(cmdLen),
    .ram_addr_out(ramAddr2), .ram_en_out(ramEn2), .ram_regce_out(ramRegce2), .ram_dout_in(ramDout2),
    .data_out(data2), .data_valid_out(dataValid2), .data_ready_in(dataReady),
    .data_last_out(dataLast2), .busy_out(busy2)
  );

  bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut1 (
    .clk_in(clk), .rst_n_in(rstN),
    .cmd_valid_in(cmdValid & useLow), .cmd_ready_out(cmdReady1),
    .cmd_addr_in(cmdAddr), .cmd_len_in(cmdLen),
    .ram_addr_out(ramAddr1), .ram_en_out(ramEn1), .ram_regce_out(ramRegce1), .ram_dout_in(ramDout1),
    .data_out(data1), .data_valid_out(dataValid1), .data_ready_in(dataReady),
    .data_last_out(dataLast1), .busy_out(busy1)
  );

  assign cmdReady  = useLow ? cmdReady1  : cmdReady2;
  assign ramEn     = useLow ? ramEn1     : ramEn2;
  assign ramRegce  = useLow ? ramRegce1  : ramRegce2;
  assign ramAddr   = useLow ? ramAddr1   : ramAddr2;
  assign dataValid = useLow ? dataValid1 : dataValid2;
  assign dataLast  = useLow ? dataLast1  : dataLast2;
  assign dataOut   = useLow ? data1      : data2;
  assign busy      = useLow ? busy1      : busy2;

  // Behavioural BRAM ports: the 2-cycle model only advances its output register under regce.
  always @(posedge clk) begin
    if (ramEn2)    stage2   <= ramMem[ramAddr2];
    if (ramRegce2) ramDout2 <= stage2;
    if (ramEn1)    ramDout1 <= ramMem[ramAddr1];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cmdReady"}, 32'(cmdReady), 32'd1);
    checkOutput({tag, "_busy"},     32'(busy),     32'd0);
    checkOutput({tag, "_ramEn"},    32'(ramEn),    32'd0);
    checkOutput({tag, "_ramRegce"}, 32'(ramRegce), 32'd0);
    checkOutput({tag, "_ramAddr"},  32'(ramAddr),  32'd0);
    checkOutput({tag, "_valid"},    32'(dataValid), 32'd0);
    checkOutput({tag, "_last"},     32'(dataLast), 32'd0);
    checkOutput({tag, "_data"},     32'(dataOut),  32'd0);
  endtask

  // Issues one command and collects everything until busy drops after the last word.
  task automatic applyStimulus(input int startAddr, input int len, input int readyMode, input int maxCycles);
    int enCount = 0;
    int popCount = 0;
    gotWords.delete();
    gotLast.delete();
    gotAddrs.delete();
    firstValid = -1; lastHs = -1; busyFall = -1; creditViol = 0;
    regceSeen = 0; busyAt1 = 0; cmdReadyAtFall = 0; timedOut = 1;
    @(negedge clk);
    cmdAddr   = AW'(startAddr);
    cmdLen    = (AW + 1)'(len);
    cmdValid  = 1'b1;
    dataReady = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= maxCycles; cyc++) begin
      @(negedge clk);
      cmdValid = 1'b0;
      if (readyMode == 1 && cyc >= 3 && cyc <= 12) dataReady = 1'b0;
      else if (readyMode == 1 && cyc > 12)         dataReady = 1'($urandom_range(0, 1));
      else                                         dataReady = 1'b1;
      if (cyc == 1) busyAt1 = int'(busy);
      if (ramRegce) regceSeen++;
      if (ramEn) begin
        gotAddrs.push_back(int'(ramAddr));
        if (enCount - popCount >= 4) creditViol++;
        enCount++;
      end
      if (dataValid) begin
        if (firstValid < 0) firstValid = cyc;
        if (dataReady) begin
          gotWords.push_back(dataOut);
          gotLast.push_back(dataLast);
          popCount++;
          if (dataLast) lastHs = cyc;
        end
      end
      if (lastHs >= 0 && cyc > lastHs && !busy) begin
        busyFall = cyc;
        cmdReadyAtFall = int'(cmdReady);
        timedOut = 0;
        break;
      end
    end
  endtask

  task automatic checkBurst(input string tag, input int startAddr, input int len);
    int lastCount = 0;
    logic [31:0] obs;
    checkOutput({tag, "_timeout"}, 32'(timedOut), 32'd0);
    checkOutput({tag, "_count"}, 32'(gotWords.size()), 32'(len));
    for (int i = 0; i < len; i++) begin
      obs = (i < gotWords.size()) ? 32'(gotWords[i]) : 32'hDEAD_BEEF;
      checkOutput($sformatf("%s_word%0d", tag, i), obs, 32'(((startAddr + i) % 1024) + 256));
    end
    foreach (gotLast[i]) if (gotLast[i]) lastCount++;
    checkOutput({tag, "_lastCount"}, 32'(lastCount), 32'd1);
    obs = (gotLast.size() == len) ? 32'(gotLast[len-1]) : 32'd0;
    checkOutput({tag, "_lastOnFinal"}, obs, 32'd1);
    checkOutput({tag, "_creditViol"}, 32'(creditViol), 32'd0);
  endtask

  initial begin
    int hsCount;
    int badCount;
    checks = 0; errors = 0;
    rstN = 1'b0; cmdValid = 1'b0; cmdAddr = '0; cmdLen = '0; dataReady = 1'b0; useLow = 1'b0;
    for (int i = 0; i < (1 << AW); i++) ramMem[i] = DW'(i + 256);
    #12;
    checkReset("por");
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] basic burst addr=5 len=4");
    applyStimulus(5, 4, 0, 40);
    checkBurst("basic", 5, 4);
    checkOutput("basic_firstValid", 32'(firstValid), 32'd4);
    checkOutput("basic_busyAt1", 32'(busyAt1), 32'd1);
    checkOutput("basic_busyFall", 32'(busyFall), 32'(lastHs + 1));
    checkOutput("basic_cmdReadyAtFall", 32'(cmdReadyAtFall), 32'd1);

    $display("[TB] wrap burst addr=1022 len=4");
    applyStimulus(1022, 4, 0, 40);
    checkBurst("wrap", 1022, 4);
    checkOutput("wrap_addrCount", 32'(gotAddrs.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("wrap_ramAddr%0d", i),
                  (i < gotAddrs.size()) ? 32'(gotAddrs[i]) : 32'hDEAD_BEEF, 32'((1022 + i) % 1024));

    $display("[TB] backpressure burst addr=40 len=16");
    applyStimulus(40, 16, 1, 400);
    checkBurst("bp", 40, 16);

    $display("[TB] zero-length command");
    badCount = 0;
    @(negedge clk);
    cmdAddr = AW'(7); cmdLen = '0; cmdValid = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      cmdValid = 1'b0;
      if (ramEn || dataValid || busy || !cmdReady) badCount++;
    end
    checkOutput("zero_activity", 32'(badCount), 32'd0);

    $display("[TB] reset mid-burst");
    hsCount = 0;
    @(negedge clk);
    cmdAddr = AW'(20); cmdLen = (AW + 1)'(16); cmdValid = 1'b1; dataReady = 1'b1;
    for (int cyc = 0; cyc < 60 && hsCount < 5; cyc++) begin
      @(negedge clk);
      cmdValid = 1'b0;
      if (dataValid && dataReady) hsCount++;
    end
    checkOutput("rst_wordsBefore", 32'(hsCount), 32'd5);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1 checkReset("midrst");
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(0, 2, 0, 40);
    checkBurst("rst", 0, 2);
    badCount = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (dataValid || ramEn) badCount++;
    end
    checkOutput("rst_noExtra", 32'(badCount), 32'd0);

    $display("[TB] throughput latency 2");
    applyStimulus(100, 16, 0, 60);
    checkBurst("tp2", 100, 16);
    checkOutput("tp2_firstValid", 32'(firstValid), 32'd4);
    checkOutput("tp2_lastCycle", 32'(lastHs), 32'(firstValid + 15));

    $display("[TB] throughput latency 1");
    useLow = 1'b1;
    applyStimulus(200, 16, 0, 60);
    checkBurst("tp1", 200, 16);
    checkOutput("tp1_firstValid", 32'(firstValid), 32'd3);
    checkOutput("tp1_lastCycle", 32'(lastHs), 32'(firstValid + 15));
    checkOutput("tp1_regce", 32'(regceSeen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side client for the team's true-dual-port BRAM: drives one RAM port (address, enable, output-register enable) to fetch a burst of consecutive words and presents them as a valid/ready stream with a last flag. It hides the RAM's fixed 1- or 2-cycle read latency and absorbs downstream backpressure in a small credit-checked FIFO, so no word is ever dropped. It sits between any frame/sample buffer BRAM and its consumer, such as a display pipeline or DSP stage.

## Interface
- DATA_WIDTH, 18, RAM word width
- ADDR_WIDTH, 10, RAM address width; depth = 2^ADDR_WIDTH
- READ_LATENCY, 2, RAM read latency in cycles: 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE; other values illegal
- FIFO_DEPTH, 4, output FIFO entries, power of two, minimum 2; at least READ_LATENCY+2 for 1 word/cycle

Ports:
- clk_in  in  1  single clock
- rst_n_in  in  1  reset, asynchronous, active-low
- cmd_valid_in  in  1  burst command valid
- cmd_ready_out  out  1  command accepted when valid&ready
- cmd_addr_in  in  ADDR_WIDTH  start address
- cmd_len_in  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH
- ram_addr_out  out  ADDR_WIDTH  RAM port address
- ram_en_out  out  1  RAM port enable, one read per high cycle
- ram_regce_out  out  1  RAM output-register enable; constant 0 when READ_LATENCY=1
- ram_dout_in  in  DATA_WIDTH  RAM port read data
- data_out  out  DATA_WIDTH  stream data
- data_valid_out  out  1  stream valid
- data_ready_in  in  1  stream ready
- data_last_out  out  1  final word of burst, qualified by valid
- busy_out  out  1  high from command accept until last word transferred

## Operation
- States: IDLE, ISSUE, DRAIN. cmd_ready_out = (state==IDLE).
- IDLE: on handshake with len≠0, latch addr and remaining=len, go to ISSUE. With len=0, accept the command, produce no output, and stay in IDLE.
- ISSUE: each cycle with credit, assert ram_en_out with ram_addr_out=addr, then addr←addr+1 mod 2^ADDR_WIDTH and remaining←remaining−1. The issue that takes remaining to 0 moves the block to DRAIN.
- Credit: issue only when inflight + fifo_count < FIFO_DEPTH. inflight counts reads issued but not yet written to the FIFO. A pop in the same cycle does not grant credit, so the check is conservative. The FIFO never overflows.
- Latency pipe: a READ_LATENCY-deep shift register of {valid, last}. When the tail is valid, ram_dout_in is written to the FIFO along with its last bit. ram_regce_out = valid bit of pipe stage 1 (only when READ_LATENCY=2).
- DRAIN: go to IDLE in the cycle after the word with last=1 is handshaken on the output.
- Output stream: data_out/data_last_out come from the FIFO head; data_valid_out = fifo_count≠0. Once valid is asserted, data and last stay stable until the handshake.
- Reset mid-burst: pipe, FIFO, counters and state clear immediately. Reads already issued are discarded. RAM contents are unaffected.

## Timing
- Reset values: cmd_ready_out=1, busy_out=0, ram_en_out=0, ram_regce_out=0, ram_addr_out=0, data_valid_out=0, data_last_out=0, data_out=0.
- Handshake in cycle 0 → first ram_en_out in cycle 1 → word on ram_dout_in in cycle 1+READ_LATENCY → data_valid_out in cycle 2+READ_LATENCY (4 for the defaults).
- With FIFO_DEPTH ≥ READ_LATENCY+2 and data_ready_in held high, the block sustains 1 word/cycle with no gaps.
- busy_out rises in cycle 1 and falls in the cycle after the last handshake, together with cmd_ready_out rising.
- Wrap: address 2^ADDR_WIDTH−1 is followed by address 0. A length of 2^ADDR_WIDTH reads every word exactly once.

## Structure
- Package bram_reader_pkg holds the state encoding (IDLE/ISSUE/DRAIN), the legal READ_LATENCY values, and the FIFO_DEPTH/credit-width derivation function.
- One sub-module: bram_reader_fifo, a synchronous FIFO with count output and first-word data available at the head. The issue FSM, credit check and latency pipe stay in the top level.

## Test plan
All scenarios use a behavioural BRAM model with matching READ_LATENCY, preloaded with mem[i]=i+0x100, and the default parameters.
- Burst addr=5, len=4, ready=1 → data 0x105,0x106,0x107,0x108; first valid 4 cycles after handshake; last only on 0x108; busy_out falls the cycle after.
- Wrap: addr=1022, len=4 → 0x4FE,0x4FF,0x100,0x101; ram_addr_out sequence 1022,1023,0,1.
- Backpressure: len=16, data_ready_in low for cycles 3–12, then random toggling → all 16 words in order with none duplicated; ram_en_out low whenever credit is exhausted; fifo_count never exceeds 4.
- len=0 → no ram_en_out, no data_valid_out, cmd_ready_out stays 1.
- Reset asserted mid-burst (after 5 words) → all outputs take their reset values asynchronously; a following burst addr=0, len=2 returns 0x100,0x101 only.
- Throughput: len=16, ready=1 → 16 consecutive data_valid_out cycles, last on cycle 16; repeat with READ_LATENCY=1 and get the first valid at cycle 3.
